// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module   : alu_ctrl_pkg
// Purpose  : State, opcode and ALU function encodings for alu_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        OPND   = 3'd3,
        MEMRD  = 3'd4,
        MEMWR  = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDA   = 4'h1,
        OP_LDB   = 4'h2,
        OP_STA   = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_INCA  = 4'h8,
        OP_INCB  = 4'h9,
        OP_MOVAB = 4'hA,
        OP_MOVBA = 4'hB,
        OP_JMP   = 4'hC,
        OP_JC    = 4'hD,
        OP_JZ    = 4'hE,
        OP_HLT   = 4'hF
    } opcode_t;

    localparam logic [2:0] F_A    = 3'b000;
    localparam logic [2:0] F_B    = 3'b001;
    localparam logic [2:0] F_INCA = 3'b010;
    localparam logic [2:0] F_INCB = 3'b011;
    localparam logic [2:0] F_ADD  = 3'b100;
    localparam logic [2:0] F_SUB  = 3'b101;
    localparam logic [2:0] F_AND  = 3'b110;
    localparam logic [2:0] F_OR   = 3'b111;

    // ALU select for the register-to-register ops; MOVAB passes A, MOVBA passes B.
    function automatic logic [2:0] alu_func(input opcode_t op);
        logic [2:0] sel;
        sel = F_A;
        case (op)
            OP_ADD:   sel = F_ADD;
            OP_SUB:   sel = F_SUB;
            OP_AND:   sel = F_AND;
            OP_OR:    sel = F_OR;
            OP_INCA:  sel = F_INCA;
            OP_INCB:  sel = F_INCB;
            OP_MOVAB: sel = F_A;
            OP_MOVBA: sel = F_B;
            default:  sel = F_A;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module   : mem_wait_timer
// Purpose  : Counts cycles a memory strobe waits for mem_ready; flags expiry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

            logic [c_cnt_w-1:0] r_count;

            // Cleared outside memory states and on every completion, so each
            // strobe starts counting from zero.
            always_ff @(posedge clk) begin
                if (!rstn || !waiting || mem_ready) begin
                    r_count <= '0;
                end else if (r_count != c_last) begin
                    r_count <= r_count + c_cnt_w'(1);
                end
            end

            // The TIMEOUT-th waiting cycle expires unless mem_ready arrives in it.
            assign expired = waiting && !mem_ready && (r_count == c_last);
        end else begin : g_no_timeout
            logic w_unused_inputs;
            assign w_unused_inputs = clk ^ rstn ^ waiting ^ mem_ready;
            assign expired         = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/alu_control_unit.sv
// ============================================================================
// Module   : alu_control_unit
// Purpose  : Fetch/decode/execute sequencer driving the 8-bit ALU datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control_unit
    import alu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    input  logic       CF,
    input  logic       ZF,
    output logic [2:0] f,
    output logic       write_cz,
    output logic       a_load,
    output logic       b_load,
    output logic       bus_src,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted,
    output logic       fault
);

    state_t  r_state;
    state_t  w_next_state;
    opcode_t r_opcode;
    logic    w_latch_op;
    logic    w_waiting;
    logic    w_expired;
    logic    w_unused_low_nibble;

    assign w_unused_low_nibble = ^mem_data[3:0];

    assign w_waiting = (r_state == FETCH) || (r_state == OPND) ||
                       (r_state == MEMRD) || (r_state == MEMWR);

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rstn     (rstn),
        .waiting  (w_waiting),
        .mem_ready(mem_ready),
        .expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= FETCH;
            r_opcode <= OP_NOP;
        end else begin
            r_state <= w_next_state;
            if (w_latch_op) begin
                r_opcode <= opcode_t'(mem_data[7:4]);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch_op   = 1'b0;
        f            = F_A;
        write_cz     = 1'b0;
        a_load       = 1'b0;
        b_load       = 1'b0;
        bus_src      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        mar_load     = 1'b0;
        addr_sel     = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;

        case (r_state)
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_latch_op   = 1'b1;
                    pc_inc       = 1'b1;
                    w_next_state = DECODE;
                end else if (w_expired) begin
                    w_next_state = FAULT;
                end
            end

            DECODE: begin
                case (r_opcode)
                    OP_NOP:                                   w_next_state = FETCH;
                    OP_LDA, OP_LDB, OP_STA,
                    OP_JMP, OP_JC, OP_JZ:                     w_next_state = OPND;
                    OP_HLT:                                   w_next_state = HALT;
                    default:                                  w_next_state = EXEC;
                endcase
            end

            EXEC: begin
                f = alu_func(r_opcode);
                case (r_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INCA: begin
                        a_load   = 1'b1;
                        write_cz = 1'b1;
                    end
                    OP_INCB: begin
                        b_load   = 1'b1;
                        write_cz = 1'b1;
                    end
                    OP_MOVAB: b_load = 1'b1;
                    OP_MOVBA: a_load = 1'b1;
                    default:  ;
                endcase
                w_next_state = FETCH;
            end

            OPND: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    case (r_opcode)
                        OP_LDA, OP_LDB: begin
                            mar_load     = 1'b1;
                            pc_inc       = 1'b1;
                            w_next_state = MEMRD;
                        end
                        OP_STA: begin
                            mar_load     = 1'b1;
                            pc_inc       = 1'b1;
                            w_next_state = MEMWR;
                        end
                        default: begin
                            // Taken jumps replace the PC; untaken ones skip the operand.
                            if ((r_opcode == OP_JMP) ||
                                (r_opcode == OP_JC && CF) ||
                                (r_opcode == OP_JZ && ZF)) begin
                                pc_load = 1'b1;
                            end else begin
                                pc_inc = 1'b1;
                            end
                            w_next_state = FETCH;
                        end
                    endcase
                end else if (w_expired) begin
                    w_next_state = FAULT;
                end
            end

            MEMRD: begin
                mem_rd   = 1'b1;
                addr_sel = 1'b1;
                bus_src  = 1'b1;
                if (mem_ready) begin
                    a_load       = (r_opcode == OP_LDA);
                    b_load       = (r_opcode == OP_LDB);
                    w_next_state = FETCH;
                end else if (w_expired) begin
                    w_next_state = FAULT;
                end
            end

            MEMWR: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    w_next_state = FETCH;
                end else if (w_expired) begin
                    w_next_state = FAULT;
                end
            end

            HALT:  halted = 1'b1;
            FAULT: fault  = 1'b1;
            default: w_next_state = FETCH;
        endcase

        // Outputs are silenced for the whole reset cycle so no partial strobe escapes.
        if (!rstn) begin
            f        = F_A;
            write_cz = 1'b0;
            a_load   = 1'b0;
            b_load   = 1'b0;
            bus_src  = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            mar_load = 1'b0;
            addr_sel = 1'b0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            halted   = 1'b0;
            fault    = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_control_unit.sv
// ============================================================================
// Module   : tb_alu_control_unit
// Purpose  : Cycle-accurate vector bench for alu_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_control_unit;

    logic       clk;
    logic       rstn;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       CF;
    logic       ZF;
    logic [2:0] f;
    logic       write_cz, a_load, b_load, bus_src, pc_inc, pc_load;
    logic       mar_load, addr_sel, mem_rd, mem_wr, halted, fault;

    alu_control_unit #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .CF       (CF),
        .ZF       (ZF),
        .f        (f),
        .write_cz (write_cz),
        .a_load   (a_load),
        .b_load   (b_load),
        .bus_src  (bus_src),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .mar_load (mar_load),
        .addr_sel (addr_sel),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .halted   (halted),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-output bit map: {f[2:0], write_cz, a_load, b_load, bus_src,
    // pc_inc, pc_load, mar_load, addr_sel, mem_rd, mem_wr, halted, fault}
    localparam logic [14:0] FLT  = 15'h0001;
    localparam logic [14:0] HLT  = 15'h0002;
    localparam logic [14:0] MWR  = 15'h0004;
    localparam logic [14:0] MRD  = 15'h0008;
    localparam logic [14:0] ASEL = 15'h0010;
    localparam logic [14:0] MAR  = 15'h0020;
    localparam logic [14:0] PCL  = 15'h0040;
    localparam logic [14:0] PCI  = 15'h0080;
    localparam logic [14:0] BSRC = 15'h0100;
    localparam logic [14:0] BLD  = 15'h0200;
    localparam logic [14:0] ALD  = 15'h0400;
    localparam logic [14:0] WCZ  = 15'h0800;

    function automatic logic [14:0] fsel(input logic [2:0] fv);
        return {fv, 12'h000};
    endfunction

    typedef struct {
        string       name;
        logic        rn;
        logic [7:0]  data;
        logic        rdy;
        logic        cf;
        logic        zf;
        logic [14:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [14:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic add(input string nm, input logic rn, input logic [7:0] d,
                       input logic r, input logic c, input logic z,
                       input logic [14:0] e);
        vec_t v;
        v.name = nm; v.rn = rn; v.data = d; v.rdy = r; v.cf = c; v.zf = z; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm);
        logic [14:0] act;
        logic [14:0] want;
        act = {f, write_cz, a_load, b_load, bus_src, pc_inc, pc_load,
               mar_load, addr_sel, mem_rd, mem_wr, halted, fault};
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %h", nm, act);
        end else begin
            want = sb_q.pop_front();
            if (act !== want) begin
                n_errors++;
                $display("FAIL %s: got %h want %h", nm, act, want);
            end
        end
    endtask

    // Drive one cycle away from the rising edge and compare before it arrives.
    task automatic step(input string nm, input logic rn, input logic [7:0] d,
                        input logic r, input logic c, input logic z,
                        input logic [14:0] e);
        @(negedge clk);
        rstn = rn; mem_data = d; mem_ready = r; CF = c; ZF = z;
        sb_q.push_back(e);
        #2;
        check(nm);
    endtask

    initial begin
        rstn = 1'b0; mem_data = 8'h00; mem_ready = 1'b0; CF = 1'b0; ZF = 1'b0;

        add("reset0",      0, 8'h00, 1, 1, 1, 15'h0);
        add("reset1",      0, 8'h40, 1, 0, 0, 15'h0);
        // ADD, zero-wait
        add("add_fetch",   1, 8'h40, 1, 0, 0, MRD | PCI);
        add("add_decode",  1, 8'hFF, 1, 0, 0, 15'h0);
        add("add_exec",    1, 8'hFF, 1, 0, 0, fsel(3'b100) | ALD | WCZ);
        // LDA with two operand wait cycles
        add("lda_fetch",   1, 8'h10, 1, 0, 0, MRD | PCI);
        add("lda_decode",  1, 8'h00, 0, 0, 0, 15'h0);
        add("lda_wait1",   1, 8'h25, 0, 0, 0, MRD);
        add("lda_wait2",   1, 8'h25, 0, 0, 0, MRD);
        add("lda_opnd",    1, 8'h25, 1, 0, 0, MRD | MAR | PCI);
        add("lda_memrd",   1, 8'h7F, 1, 0, 0, MRD | ASEL | BSRC | ALD);
        // JC not taken, JZ taken, JC taken, JZ not taken, JMP
        add("jc_fetch",    1, 8'hD0, 1, 0, 0, MRD | PCI);
        add("jc_decode",   1, 8'h00, 1, 0, 0, 15'h0);
        add("jc_nt",       1, 8'h30, 1, 0, 1, MRD | PCI);
        add("jz_fetch",    1, 8'hE0, 1, 0, 0, MRD | PCI);
        add("jz_decode",   1, 8'h00, 1, 0, 0, 15'h0);
        add("jz_t",        1, 8'h30, 1, 0, 1, MRD | PCL);
        add("jc2_fetch",   1, 8'hD3, 1, 0, 0, MRD | PCI);
        add("jc2_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        add("jc_t",        1, 8'h30, 1, 1, 0, MRD | PCL);
        add("jz2_fetch",   1, 8'hE0, 1, 0, 0, MRD | PCI);
        add("jz2_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        add("jz_nt",       1, 8'h30, 1, 1, 0, MRD | PCI);
        add("jmp_fetch",   1, 8'hC0, 1, 0, 0, MRD | PCI);
        add("jmp_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        add("jmp",         1, 8'h30, 1, 0, 0, MRD | PCL);
        // ALU ops; low nibble ignored
        add("sub_fetch",   1, 8'h5F, 1, 0, 0, MRD | PCI);
        add("sub_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        add("sub_exec",    1, 8'h00, 1, 0, 0, fsel(3'b101) | ALD | WCZ);
        add("movab_fetch", 1, 8'hA0, 1, 0, 0, MRD | PCI);
        add("movab_dec",   1, 8'h00, 1, 0, 0, 15'h0);
        add("movab_exec",  1, 8'h00, 1, 0, 0, fsel(3'b000) | BLD);
        add("movba_fetch", 1, 8'hB0, 1, 0, 0, MRD | PCI);
        add("movba_dec",   1, 8'h00, 1, 0, 0, 15'h0);
        add("movba_exec",  1, 8'h00, 1, 0, 0, fsel(3'b001) | ALD);
        add("incb_fetch",  1, 8'h90, 1, 0, 0, MRD | PCI);
        add("incb_dec",    1, 8'h00, 1, 0, 0, 15'h0);
        add("incb_exec",   1, 8'h00, 1, 0, 0, fsel(3'b011) | BLD | WCZ);
        add("nop_fetch",   1, 8'h0A, 1, 0, 0, MRD | PCI);
        add("nop_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        // LDB with a data wait, STA with a write wait
        add("ldb_fetch",   1, 8'h20, 1, 0, 0, MRD | PCI);
        add("ldb_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        add("ldb_opnd",    1, 8'h44, 1, 0, 0, MRD | MAR | PCI);
        add("ldb_wait",    1, 8'h00, 0, 0, 0, MRD | ASEL | BSRC);
        add("ldb_memrd",   1, 8'h99, 1, 0, 0, MRD | ASEL | BSRC | BLD);
        add("sta_fetch",   1, 8'h30, 1, 0, 0, MRD | PCI);
        add("sta_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        add("sta_opnd",    1, 8'h50, 1, 0, 0, MRD | MAR | PCI);
        add("sta_wait",    1, 8'h00, 0, 0, 0, MWR | ASEL);
        add("sta_memwr",   1, 8'h00, 1, 0, 0, MWR | ASEL);
        // Reset in the middle of MEMWR
        add("rst_fetch",   1, 8'h30, 1, 0, 0, MRD | PCI);
        add("rst_decode",  1, 8'h00, 1, 0, 0, 15'h0);
        add("rst_opnd",    1, 8'h60, 1, 0, 0, MRD | MAR | PCI);
        add("rst_memwr",   1, 8'h00, 0, 0, 0, MWR | ASEL);
        add("rst_mid",     0, 8'h00, 0, 1, 1, 15'h0);
        add("rst_refetch", 1, 8'h00, 0, 0, 0, MRD);
        add("rst_fetch2",  1, 8'h40, 1, 0, 0, MRD | PCI);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rn, vecs[i].data, vecs[i].rdy,
                 vecs[i].cf, vecs[i].zf, vecs[i].exp);
        end

        // STA whose write never completes: 15 wait cycles then permanent fault.
        step("to_reset",  0, 8'h00, 0, 0, 0, 15'h0);
        step("to_fetch",  1, 8'h30, 1, 0, 0, MRD | PCI);
        step("to_decode", 1, 8'h00, 1, 0, 0, 15'h0);
        step("to_opnd",   1, 8'h70, 1, 0, 0, MRD | MAR | PCI);
        for (int k = 0; k < 15; k++) step("to_wait", 1, 8'h00, 0, 0, 0, MWR | ASEL);
        for (int k = 0; k < 6; k++) step("to_fault", 1, 8'hF0, k[0], 1, 1, FLT);

        // Same STA with mem_ready on the 15th wait cycle completes normally.
        step("ok_reset",  0, 8'h00, 0, 0, 0, 15'h0);
        step("ok_fetch",  1, 8'h30, 1, 0, 0, MRD | PCI);
        step("ok_decode", 1, 8'h00, 1, 0, 0, 15'h0);
        step("ok_opnd",   1, 8'h70, 1, 0, 0, MRD | MAR | PCI);
        for (int k = 0; k < 14; k++) step("ok_wait", 1, 8'h00, 0, 0, 0, MWR | ASEL);
        step("ok_last",   1, 8'h00, 1, 0, 0, MWR | ASEL);
        step("ok_next",   1, 8'h00, 0, 0, 0, MRD);

        // HLT: halted after FETCH+DECODE and held for 20 cycles regardless of inputs.
        step("hlt_fetch",  1, 8'hF0, 1, 0, 0, MRD | PCI);
        step("hlt_decode", 1, 8'h00, 1, 0, 0, 15'h0);
        for (int k = 0; k < 20; k++) begin
            step("hlt_hold", 1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), HLT);
        end
        step("hlt_reset", 0, 8'h00, 1, 0, 0, 15'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
